// File: rtl/pivot_search_seq.sv
// Sequential pivot finder: scans the strict upper triangle of an N_STOCKS x N_STOCKS matrix
// and returns the largest element. Define PIVOT_SEARCH_ABS_EN to rank by magnitude instead of signed value.
module pivot_search_seq #(
    parameter int WIDTH    = 16,
    parameter int N_STOCKS = 4,
    localparam int IW      = (N_STOCKS > 2) ? $clog2(N_STOCKS) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic signed [WIDTH-1:0] thresh_in,
    output logic                    rd_en_out,
    output logic [IW-1:0]           rd_row_out,
    output logic [IW-1:0]           rd_col_out,
    input  logic signed [WIDTH-1:0] rd_data_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [IW-1:0]           pivot_i_out,
    output logic [IW-1:0]           pivot_j_out,
    output logic signed [WIDTH-1:0] pivot_val_out,
    output logic                    converged_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_STOCKS - 1);
    localparam logic [IW-1:0] LAST_ROW = IW'(N_STOCKS - 2);

    state_t state, state_next;

    logic [IW-1:0]           row, col;
    logic                    pipe_valid;
    logic [IW-1:0]           pipe_row, pipe_col;
    logic                    seeded;
    logic [IW-1:0]           best_i, best_j;
    logic signed [WIDTH-1:0] best_val;
    logic [WIDTH-1:0]        thresh_q;

    logic                    take;
    logic [IW-1:0]           cand_i, cand_j;
    logic signed [WIDTH-1:0] cand_val;

    // Both modes map the key onto an unsigned ordering so one comparator serves either build.
    function automatic logic [WIDTH-1:0] key_of(input logic [WIDTH-1:0] v);
`ifdef PIVOT_SEARCH_ABS_EN
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
`else
        return {~v[WIDTH-1], v[WIDTH-2:0]};
`endif
    endfunction

    function automatic logic [WIDTH-1:0] thresh_key(input logic [WIDTH-1:0] t);
`ifdef PIVOT_SEARCH_ABS_EN
        return t;
`else
        return {~t[WIDTH-1], t[WIDTH-2:0]};
`endif
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_in) state_next = SCAN;
            SCAN:  if (row == LAST_ROW && col == LAST_IDX) state_next = DRAIN;
            DRAIN: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en_out  = (state == SCAN);
        rd_row_out = (state == SCAN) ? row : '0;
        rd_col_out = (state == SCAN) ? col : '0;
        busy_out   = (state == SCAN) || (state == DRAIN);
        done_out   = (state == DONE);
    end

    always_comb begin
        take     = !seeded || (key_of(rd_data_in) > key_of(best_val));
        cand_i   = take ? pipe_row   : best_i;
        cand_j   = take ? pipe_col   : best_j;
        cand_val = take ? rd_data_in : best_val;
    end

    // The last datum arrives during DRAIN, so results latch from the live candidate on the DRAIN->DONE edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row           <= '0;
            col           <= '0;
            pipe_valid    <= 1'b0;
            pipe_row      <= '0;
            pipe_col      <= '0;
            seeded        <= 1'b0;
            best_i        <= '0;
            best_j        <= '0;
            best_val      <= '0;
            thresh_q      <= '0;
            pivot_i_out   <= '0;
            pivot_j_out   <= '0;
            pivot_val_out <= '0;
            converged_out <= 1'b0;
        end else begin
            if (state == IDLE && start_in) begin
                row      <= '0;
                col      <= IW'(1);
                thresh_q <= thresh_in;
                seeded   <= 1'b0;
            end else if (state == SCAN) begin
                if (col == LAST_IDX) begin
                    row <= row + IW'(1);
                    col <= row + IW'(1) + IW'(1);
                end else begin
                    col <= col + IW'(1);
                end
            end
            pipe_valid <= (state == SCAN);
            pipe_row   <= row;
            pipe_col   <= col;
            if (pipe_valid) begin
                best_i   <= cand_i;
                best_j   <= cand_j;
                best_val <= cand_val;
                seeded   <= 1'b1;
            end
            if (state == DRAIN) begin
                pivot_i_out   <= cand_i;
                pivot_j_out   <= cand_j;
                pivot_val_out <= cand_val;
                converged_out <= key_of(cand_val) < thresh_key(thresh_q);
            end
        end
    end

endmodule
